// File: rtl/reg_window_file.sv
// Windowed register file for the p18240 datapath.
// NWIN physical windows of NREGS registers form a circular buffer; when the
// buffer overflows or underflows, the oldest window is spilled to (or filled
// back from) an external memory over a req/ack handshake while busy is high.
module reg_window_file #(
  parameter int WIDTH       = 16,
  parameter int NREGS       = 8,
  parameter int NWIN        = 4,
  parameter int SPILL_DEPTH = 16,
  localparam int SW = $clog2(NREGS),
  localparam int WW = $clog2(NWIN),
  localparam int AW = $clog2(SPILL_DEPTH * NREGS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [SW-1:0]          selA,
  input  logic [SW-1:0]          selB,
  output logic [WIDTH-1:0]       outA,
  output logic [WIDTH-1:0]       outB,
  output logic [NREGS*WIDTH-1:0] outView,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load_L,
  input  logic [1:0]             winAddSub,
  output logic [WW-1:0]          cwp,
  output logic                   busy,
  output logic                   winErr,
  output logic                   memReq,
  output logic                   memWe,
  output logic [AW-1:0]          memAddr,
  output logic [WIDTH-1:0]       memWData,
  input  logic [WIDTH-1:0]       memRData,
  input  logic                   memAck
);

  localparam int SPW = $clog2(SPILL_DEPTH + 1);
  localparam int OW  = $clog2(NWIN + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SPILL = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;

  localparam logic [OW-1:0]  OCC_FULL = OW'(NWIN);
  localparam logic [OW-1:0]  OCC_ONE  = OW'(1);
  localparam logic [SPW-1:0] SP_FULL  = SPW'(SPILL_DEPTH);
  localparam logic [SW-1:0]  K_LAST   = SW'(NREGS - 1);

  logic [1:0]     state;
  logic [OW-1:0]  occupied;
  logic [SPW-1:0] spilled;
  logic [SW-1:0]  k;
  logic [NWIN-1:0][NREGS-1:0][WIDTH-1:0] regs;

  logic [WW-1:0]  cwp_up;
  logic [WW-1:0]  cwp_dn;
  logic           push;
  logic           pop;
  logic [SPW-1:0] blk;

  assign cwp_up = cwp + 1'b1;
  assign cwp_dn = cwp - 1'b1;
  assign push   = (winAddSub == 2'b01);
  assign pop    = (winAddSub == 2'b10);

  // Read ports and the whole-window view always show the current window
  always_comb begin
    outA    = regs[cwp][selA];
    outB    = regs[cwp][selB];
    outView = regs[cwp];
  end

  // Memory side of the handshake: spills go to the next free block, fills read the last used one
  always_comb begin
    blk      = (state == FILL) ? spilled - 1'b1 : spilled;
    busy     = (state != IDLE);
    memReq   = (state != IDLE);
    memWe    = (state == SPILL);
    memAddr  = '0;
    memWData = '0;
    if (state != IDLE) memAddr = AW'(32'(blk) * NREGS + 32'(k));
    if (state == SPILL) memWData = regs[cwp_up][k];
  end

  // Register writes, window pointer bookkeeping and the spill/fill sequencer
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cwp      <= '0;
      occupied <= OCC_ONE;
      spilled  <= '0;
      k        <= '0;
      winErr   <= 1'b0;
      regs     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!load_L) regs[cwp][selA] <= in;
          if (push) begin
            if (occupied != OCC_FULL) begin
              cwp      <= cwp_up;
              occupied <= occupied + 1'b1;
            end else if (spilled != SP_FULL) begin
              state <= SPILL;
              k     <= '0;
            end else begin
              winErr <= 1'b1;
            end
          end else if (pop) begin
            if (occupied != OCC_ONE) begin
              cwp      <= cwp_dn;
              occupied <= occupied - 1'b1;
            end else if (spilled != '0) begin
              state <= FILL;
              k     <= '0;
            end else begin
              winErr <= 1'b1;
            end
          end
        end
        SPILL: begin
          if (memAck) begin
            if (k == K_LAST) begin
              spilled <= spilled + 1'b1;
              cwp     <= cwp_up;
              k       <= '0;
              state   <= IDLE;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        FILL: begin
          if (memAck) begin
            regs[cwp_dn][k] <= memRData;
            if (k == K_LAST) begin
              spilled <= spilled - 1'b1;
              cwp     <= cwp_dn;
              k       <= '0;
              state   <= IDLE;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
